// File: rtl/lc4_alu_wb_if.sv
// Bundle of the ALU-side and writeback-side signals of lc4_alu_wb.
// The master modport belongs to the agent that presents ALU ops and consumes
// writeback entries. The slave modport belongs to the writeback block.
interface lc4_alu_wb_if #(
    parameter int WORD_SIZE = 64,
    parameter int INSN      = 19,
    parameter int IADDR     = 10
);
    // upstream ALU op
    logic                 i_valid;
    logic                 o_ready;
    logic [INSN:0]        i_insn;
    logic [IADDR:0]       i_pc;
    logic [WORD_SIZE-1:0] i_r1data;
    logic [WORD_SIZE-1:0] i_r2data;
    logic [WORD_SIZE-1:0] i_result;
    logic                 o_carry;

    // downstream writeback entry
    logic                 o_valid;
    logic                 i_wb_ready;
    logic [WORD_SIZE-1:0] o_result;
    logic                 o_wen;
    logic [2:0]           o_wsel;
    logic                 o_nzp_we;
    logic [2:0]           o_nzp;

    modport master (
        output i_valid, i_insn, i_pc, i_r1data, i_r2data, i_result, i_wb_ready,
        input  o_ready, o_carry, o_valid, o_result, o_wen, o_wsel, o_nzp_we, o_nzp
    );

    modport slave (
        input  i_valid, i_insn, i_pc, i_r1data, i_r2data, i_result, i_wb_ready,
        output o_ready, o_carry, o_valid, o_result, o_wen, o_wsel, o_nzp_we, o_nzp
    );
endinterface

// File: rtl/lc4_alu_wb.sv
// LC4 ALU writeback stage: registers the ALU result together with its
// register/NZP write controls in a 2-entry in-order skid buffer, and owns the
// architectural carry flag that feeds back into the ALU.
module lc4_alu_wb #(
    parameter int WORD_SIZE = 64,
    parameter int INSN      = 19,
    parameter int IADDR     = 10
) (
    input logic          clk,
    input logic          rst,
    lc4_alu_wb_if.slave  bus
);

    typedef struct packed {
        logic signed [WORD_SIZE-1:0] result;
        logic                        wen;
        logic [2:0]                  wsel;
        logic                        nzp_we;
        logic [2:0]                  nzp;
    } wb_ent_t;

    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;

    // {N,Z,P} of a result; exactly one bit is ever set.
    function automatic logic [2:0] nzp_of(input logic signed [WORD_SIZE-1:0] r);
        logic n;
        logic z;
        n = r[WORD_SIZE-1];
        z = (r == '0);
        return {n, z, !n && !z};
    endfunction

    // Ops that write the register file (and therefore also the NZP flags).
    function automatic logic writes_reg(input logic [3:0] op);
        case (op)
            OP_ARITH, OP_LOGIC, OP_CONST, OP_HICONST, OP_SHIFT: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // Carry after accepting an op: ADD produces its carry-out, SDR1/SDR2 shift
    // the LSB of their source operand into carry, everything else preserves it.
    function automatic logic carry_next(
        input logic [3:0]           op,
        input logic [2:0]           sub,
        input logic [WORD_SIZE-1:0] r1,
        input logic [WORD_SIZE-1:0] r2,
        input logic                 cur
    );
        logic [WORD_SIZE:0] sum;
        sum = {1'b0, r1} + {1'b0, r2};
        if (op == OP_ARITH && sub == 3'b000)
            return sum[WORD_SIZE];
        else if (op == OP_ARITH && sub == 3'b011)
            return r1[0];
        else if (op == OP_SHIFT && sub[2:1] == 2'b11)
            return r2[0];
        else
            return cur;
    endfunction

    logic [3:0] op_p0;
    logic [2:0] sub_p0;
    wb_ent_t    ent_p0;
    logic       accept_p0;
    logic       xfer_p1;

    wb_ent_t    out_p1;
    wb_ent_t    skid_p1;
    logic       vld_p1;
    logic       skid_vld_p1;
    logic       ready_p1;
    logic       carry_p1;

    // Instruction fields not needed for writeback (PC, upper bus bits, rs/rt/imm).
    logic       unused_bits;
    assign unused_bits = ^{bus.i_pc, bus.i_insn[INSN:16], bus.i_insn[8:6], bus.i_insn[2:0]};

    // ---- stage p0: decode the incoming op into a writeback entry ----
    assign op_p0     = bus.i_insn[15:12];
    assign sub_p0    = bus.i_insn[5:3];
    assign accept_p0 = bus.i_valid && ready_p1;
    assign xfer_p1   = vld_p1 && bus.i_wb_ready;

    // Build the entry that an accept would store.
    always_comb begin
        ent_p0        = '0;
        ent_p0.result = bus.i_result;
        ent_p0.wen    = writes_reg(op_p0);
        ent_p0.wsel   = bus.i_insn[11:9];
        ent_p0.nzp_we = writes_reg(op_p0) || (op_p0 == OP_CMP);
        ent_p0.nzp    = nzp_of(bus.i_result);
    end

    // ---- stage p1: output entry + skid entry, carry flag ----
    // Skid buffer occupancy and carry update; ready only depends on skid state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_p1      <= '0;
            skid_p1     <= '0;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ready_p1    <= 1'b1;
            carry_p1    <= 1'b0;
        end else begin
            if (accept_p0)
                carry_p1 <= carry_next(op_p0, sub_p0, bus.i_r1data, bus.i_r2data, carry_p1);

            case ({vld_p1, skid_vld_p1})
                2'b00: begin
                    if (accept_p0) begin
                        out_p1 <= ent_p0;
                        vld_p1 <= 1'b1;
                    end
                end
                2'b10: begin
                    if (accept_p0 && xfer_p1) begin
                        // Old entry leaves while the new one takes its place.
                        out_p1 <= ent_p0;
                    end else if (accept_p0) begin
                        skid_p1     <= ent_p0;
                        skid_vld_p1 <= 1'b1;
                        ready_p1    <= 1'b0;
                    end else if (xfer_p1) begin
                        vld_p1 <= 1'b0;
                    end
                end
                2'b11: begin
                    // Full: no accept possible, drain skid into output on transfer.
                    if (xfer_p1) begin
                        out_p1      <= skid_p1;
                        skid_vld_p1 <= 1'b0;
                        ready_p1    <= 1'b1;
                    end
                end
                default: begin
                    // Skid without an output entry cannot occur; recover to empty.
                    vld_p1      <= 1'b0;
                    skid_vld_p1 <= 1'b0;
                    ready_p1    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready  = ready_p1;
    assign bus.o_carry  = carry_p1;
    assign bus.o_valid  = vld_p1;
    assign bus.o_result = out_p1.result;
    assign bus.o_wen    = out_p1.wen;
    assign bus.o_wsel   = out_p1.wsel;
    assign bus.o_nzp_we = out_p1.nzp_we;
    assign bus.o_nzp    = out_p1.nzp;

endmodule

// File: tb/tb_lc4_alu_wb.sv
// Directed bench for lc4_alu_wb: reset, op decode/NZP/carry, skid stall and
// release ordering, reset while stalled.
module tb_lc4_alu_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    lc4_alu_wb_if #(.WORD_SIZE(64), .INSN(19), .IADDR(10)) bus ();

    lc4_alu_wb #(.WORD_SIZE(64), .INSN(19), .IADDR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    // insn[15:0] encodings
    localparam logic [19:0] I_ADD_R3  = 20'h01601; // 0001 011 000 000 001
    localparam logic [19:0] I_SUB_R4  = 20'h01811; // 0001 100 000 010 001
    localparam logic [19:0] I_SDR1_R2 = 20'h01418; // 0001 010 000 011 000
    localparam logic [19:0] I_SDR2_R1 = 20'h0A230; // 1010 001 000 11 0000
    localparam logic [19:0] I_CMP     = 20'h02000; // 0010 000 ...
    localparam logic [19:0] I_AND_R5  = 20'h05A00; // 0101 101 ...
    localparam logic [19:0] I_BR      = 20'h00E00; // 0000 ...

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [19:0] insn, input logic [63:0] r1,
                        input logic [63:0] r2, input logic [63:0] res);
        bus.i_valid  = 1'b1;
        bus.i_insn   = insn;
        bus.i_pc     = 11'h12;
        bus.i_r1data = r1;
        bus.i_r2data = r2;
        bus.i_result = res;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        bus.i_wb_ready = 1'b1;
        send(I_ADD_R3, ALL1, 64'h1, 64'h0);   // offered during reset, must be ignored

        // reset held 2 cycles with i_valid=1
        @(negedge clk);
        @(negedge clk);
        check_val("rst_valid", {63'd0, bus.o_valid}, 64'd0);
        check_val("rst_carry", {63'd0, bus.o_carry}, 64'd0);
        check_val("rst_result", bus.o_result, 64'd0);
        check_val("rst_ctl", {57'd0, bus.o_wen, bus.o_wsel, bus.o_nzp_we, bus.o_nzp}, 64'd0);
        idle();
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", {63'd0, bus.o_ready}, 64'd1);
        check_val("post_rst_valid", {63'd0, bus.o_valid}, 64'd0);

        // ADD with carry-out, zero result
        send(I_ADD_R3, ALL1, 64'h1, 64'h0);
        @(negedge clk);
        check_val("add_valid", {63'd0, bus.o_valid}, 64'd1);
        check_val("add_result", bus.o_result, 64'd0);
        check_val("add_nzp", {61'd0, bus.o_nzp}, 64'b010);
        check_val("add_wen", {63'd0, bus.o_wen}, 64'd1);
        check_val("add_wsel", {61'd0, bus.o_wsel}, 64'd3);
        check_val("add_nzp_we", {63'd0, bus.o_nzp_we}, 64'd1);
        check_val("add_carry", {63'd0, bus.o_carry}, 64'd1);

        // CMP negative: NZP only, carry preserved
        send(I_CMP, 64'h5, 64'h9, ALL1);
        @(negedge clk);
        check_val("cmp_nzp", {61'd0, bus.o_nzp}, 64'b100);
        check_val("cmp_nzp_we", {63'd0, bus.o_nzp_we}, 64'd1);
        check_val("cmp_wen", {63'd0, bus.o_wen}, 64'd0);
        check_val("cmp_carry", {63'd0, bus.o_carry}, 64'd1);

        // SUB whose operands would overflow an add: carry still preserved
        send(I_SUB_R4, ALL1, 64'h1, 64'h7);
        @(negedge clk);
        check_val("sub_result", bus.o_result, 64'h7);
        check_val("sub_wsel_nzp", {58'd0, bus.o_wsel, bus.o_nzp}, {58'd0, 3'd4, 3'b001});
        check_val("sub_carry", {63'd0, bus.o_carry}, 64'd1);

        // SDR1 r1=0 clears carry, then SDR2 r2=1 / SDR1 r1=2 back-to-back
        send(I_SDR1_R2, 64'h0, 64'h0, 64'h0);
        @(negedge clk);
        check_val("sdr1a_carry", {63'd0, bus.o_carry}, 64'd0);
        send(I_SDR2_R1, 64'h0, 64'h1, 64'h3);
        @(negedge clk);
        check_val("sdr2_carry", {63'd0, bus.o_carry}, 64'd1);
        check_val("sdr2_wen_wsel", {60'd0, bus.o_wen, bus.o_wsel}, {60'd0, 1'b1, 3'd1});
        send(I_SDR1_R2, 64'h2, 64'h0, 64'h1);
        @(negedge clk);
        check_val("sdr1b_carry", {63'd0, bus.o_carry}, 64'd0);
        check_val("sdr1b_wsel", {61'd0, bus.o_wsel}, 64'd2);

        // branch-class op: no writes at all
        send(I_BR, 64'h0, 64'h0, 64'h4);
        @(negedge clk);
        check_val("br_wen", {63'd0, bus.o_wen}, 64'd0);
        check_val("br_nzp_we", {63'd0, bus.o_nzp_we}, 64'd0);
        idle();
        @(negedge clk);
        check_val("drained_valid", {63'd0, bus.o_valid}, 64'd0);

        // stall: three ops offered, two accepted, third held
        bus.i_wb_ready = 1'b0;
        send(I_AND_R5, 64'h0, 64'h0, 64'h11);
        @(negedge clk);
        check_val("st_a_valid", {63'd0, bus.o_valid}, 64'd1);
        check_val("st_a_ready", {63'd0, bus.o_ready}, 64'd1);
        send(I_AND_R5, 64'h0, 64'h0, 64'h22);
        @(negedge clk);
        check_val("st_b_ready", {63'd0, bus.o_ready}, 64'd0);
        check_val("st_b_hold", bus.o_result, 64'h11);
        send(I_AND_R5, 64'h0, 64'h0, 64'h33);
        @(negedge clk);
        check_val("st_c_ready", {63'd0, bus.o_ready}, 64'd0);
        check_val("st_c_hold", bus.o_result, 64'h11);
        bus.i_wb_ready = 1'b1;          // A leaves at next edge, C still offered
        @(negedge clk);
        check_val("rel_b", bus.o_result, 64'h22);
        check_val("rel_b_ready", {63'd0, bus.o_ready}, 64'd1);
        @(negedge clk);                 // C accepted while B leaves
        idle();
        check_val("rel_c", bus.o_result, 64'h33);
        check_val("rel_c_valid", {63'd0, bus.o_valid}, 64'd1);
        @(negedge clk);
        check_val("rel_empty", {63'd0, bus.o_valid}, 64'd0);

        // reset with two entries stalled
        bus.i_wb_ready = 1'b0;
        send(I_SDR2_R1, 64'h0, 64'h1, 64'h44);
        @(negedge clk);
        check_val("pre_rst_carry", {63'd0, bus.o_carry}, 64'd1);
        send(I_AND_R5, 64'h0, 64'h0, 64'h55);
        @(negedge clk);
        idle();
        check_val("pre_rst_ready", {63'd0, bus.o_ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_wb_ready = 1'b1;
        check_val("mid_rst_valid", {63'd0, bus.o_valid}, 64'd0);
        check_val("mid_rst_ready", {63'd0, bus.o_ready}, 64'd1);
        check_val("mid_rst_carry", {63'd0, bus.o_carry}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("post_rst_quiet", {63'd0, bus.o_valid}, 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
